seq_divider: RTL
================

# seq_divider

Multi-cycle 32-bit integer divider that produces quotient and remainder with a start/done handshake. It is the inverse companion of the ALU's single-cycle multiply path: the execute stage hands it `div`/`divu` operands and stalls on `busy`. This keeps the large combinational divide out of the critical ALU path. It uses radix-2 restoring division, one quotient bit per clock.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only while `busy`=0.
- `is_signed`  in  1  1 = two's-complement divide, 0 = unsigned.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `busy`  out  1  high from the edge after acceptance until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  WIDTH  registered quotient; holds until the next `done`.
- `remainder`  out  WIDTH  registered remainder; holds until the next `done`.
- `div_by_zero`  out  1  qualifies the current results; updated with `done`.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 latches the operands, the sign flags, and |dividend|, |divisor| (magnitudes only when `is_signed`).
  - Clears the partial remainder and sets count=0, then goes to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left 1.
  - trial = rem − divisor_mag (WIDTH+1 bits).
  - If trial ≥ 0: rem = trial and quo[0] = 1; else quo[0] = 0.
  - count++. At count = WIDTH−1, go to FIX.
- FIX:
  - Apply signs: quotient is negated iff the signs differ; remainder takes the dividend's sign.
  - Register the outputs, pulse `done`, return to IDLE.
- Divisor = 0 (runs full latency):
  - quotient = all ones, remainder = dividend (unmodified), `div_by_zero`=1.
- Signed overflow (−2^(WIDTH−1) / −1):
  - quotient = 0x80000000, remainder = 0, `div_by_zero`=0.
  - Achieved naturally by magnitude arithmetic with WIDTH-bit wrap; no special case required.
- `start` while `busy`=1 is ignored; in-flight operands are unaffected.
- `start` in the same cycle as `done` (FSM already in IDLE) is accepted.
- Arithmetic: magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) as an unsigned value. The internal trial subtraction is WIDTH+1 bits wide.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, FSM=IDLE, count=0.
- Edge E0 samples `start` and sets `busy`=1. Edges E1..E32 perform iterations. Edge E33 sets `done`=1, `busy`=0 and updates results.
- Latency is fixed at 33 clocks from acceptance to `done` for all operand values.
- `done` is high exactly one cycle; it drops at E34 even if a new `start` was accepted at E33.
- Asserting `rst_n`=0 mid-operation aborts immediately (asynchronously). All outputs return to reset values and no `done` is generated. The first `start` after release behaves normally.
- Outputs are glitch-free registered signals; none depend combinationally on inputs.

## Test plan
- Unsigned 100 / 7, `start` for one cycle -> `done` exactly 33 edges later with q=14, r=2, `div_by_zero`=0; `busy` high for 33 cycles.
- Signed −7 / 2 -> q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Signed 7 / −2 -> q=−3, r=1. Unsigned 0xFFFFFFF9 / 2 -> q=0x7FFFFFFC, r=1.
- Divisor 0 with dividend 0x12345678 (both signed and unsigned) -> q=0xFFFFFFFF, r=0x12345678, `div_by_zero`=1 after 33 clocks.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, `div_by_zero`=0.
- Start 100/7, then pulse `start` with 9/3 at cycles 5 and 20 -> only one `done`, with q=14, r=2. Start 9/3 in the `done` cycle -> second `done` 33 clocks later with q=3, r=0.
- Start 1000/10, drive `rst_n` low at cycle 15 -> `busy`, `done` and outputs are 0 immediately. Release, start 50/5 -> q=10, r=0 after 33 clocks.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock.
// Signed/unsigned div+rem with start/done handshake, fixed 33-clock latency.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dmag;
   logic [WIDTH-1:0] r_dvd;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dvz;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_dz_out;

   logic             w_dd_neg;
   logic             w_ds_neg;
   logic [WIDTH-1:0] w_dd_mag;
   logic [WIDTH-1:0] w_ds_mag;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   // Operand magnitudes; -2^(W-1) wraps to itself, read as unsigned.
   assign w_dd_neg = is_signed & dividend[WIDTH-1];
   assign w_ds_neg = is_signed & divisor[WIDTH-1];
   assign w_dd_mag = w_dd_neg ? -dividend : dividend;
   assign w_ds_mag = w_ds_neg ? -divisor : divisor;

   // Trial subtract on the W+1-bit shifted remainder. A set top bit
   // means it already exceeds any W-bit divisor, and the W-bit
   // difference is then exact, so the W+1-bit trial splits cleanly.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_ge    = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_dmag);
   assign w_diff  = w_shift[WIDTH-1:0] - r_dmag;

   // Sign fixup; divide-by-zero returns all ones and the raw dividend.
   assign w_q_fix = r_dvz ? '1    : (r_neg_q ? -r_quo : r_quo);
   assign w_r_fix = r_dvz ? r_dvd : (r_neg_r ? -r_rem : r_rem);

   // FSM, iteration datapath and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dmag   <= '0;
         r_dvd    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dvz    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_q_out  <= '0;
         r_r_out  <= '0;
         r_dz_out <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rem   <= '0;
                  r_quo   <= w_dd_mag;
                  r_dmag  <= w_ds_mag;
                  r_dvd   <= dividend;
                  r_neg_q <= w_dd_neg ^ w_ds_neg;
                  r_neg_r <= w_dd_neg;
                  r_dvz   <= (divisor == '0);
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_q_out  <= w_q_fix;
               r_r_out  <= w_r_fix;
               r_dz_out <= r_dvz;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_cnt    <= '0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_q_out;
   assign remainder   = r_r_out;
   assign div_by_zero = r_dz_out;

endmodule
